// File: rtl/spi_master_multi.sv
// spi_master_multi: full-duplex SPI master with runtime CPOL/CPHA and CS_COUNT active-low selects.
// Latency: busy_out high for (2*SIZE+2)*CLK_DIV cycles; data_out and done_out update as busy_out falls.
// Backpressure: send_enable_in ignored while busy and in the done_out cycle. Macro SPI_LSB_FIRST_EN selects LSB-first.
module spi_master_multi #(
    parameter int SIZE     = 40,
    parameter int CLK_DIV  = 3,
    parameter int CS_COUNT = 4,
    parameter int CS_WIDTH = 2
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [SIZE-1:0]     data_in,
    input  logic                send_enable_in,
    input  logic [1:0]          mode_in,
    input  logic [CS_WIDTH-1:0] cs_sel_in,
    input  logic                serial_in,
    output logic [SIZE-1:0]     data_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                clk_out,
    output logic                serial_out,
    output logic [CS_COUNT-1:0] cs_out
);

    localparam int BIT_W = $clog2(2*SIZE+1);
    localparam int DIV_W = $clog2(CLK_DIV+1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV-1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(2*SIZE-1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    half_q, half_d;
    logic [SIZE-1:0]     tx_q, tx_d;
    logic [SIZE-1:0]     rx_q, rx_d;
    logic [SIZE-1:0]     data_q, data_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [CS_COUNT-1:0] cs_q, cs_d;

    // Half-period bookkeeping: enter_half marks the edge where a new SCLK half starts.
    logic                enter_half;
    logic                half_odd;

    // Bit-order views of the transmit source and receive shift register.
    logic                head_in, head_q;
    logic [SIZE-1:0]     tail_in, tail_q, rx_push;

`ifdef SPI_LSB_FIRST_EN
    assign head_in = data_in[0];
    assign tail_in = {1'b0, data_in[SIZE-1:1]};
    assign head_q  = tx_q[0];
    assign tail_q  = {1'b0, tx_q[SIZE-1:1]};
    assign rx_push = {serial_in, rx_q[SIZE-1:1]};
`else
    assign head_in = data_in[SIZE-1];
    assign tail_in = {data_in[SIZE-2:0], 1'b0};
    assign head_q  = tx_q[SIZE-1];
    assign tail_q  = {tx_q[SIZE-2:0], 1'b0};
    assign rx_push = {rx_q[SIZE-2:0], serial_in};
`endif

    // Next-state logic: sequencing, SCLK generation and the shift/sample actions per edge.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_d     = data_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        enter_half = 1'b0;
        half_odd   = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle still counts as busy for handshake purposes.
                if (send_enable_in && !done_q) begin
                    state_d = SETUP;
                    div_d   = '0;
                    half_d  = '0;
                    mode_d  = mode_in;
                    busy_d  = 1'b1;
                    sclk_d  = mode_in[1];
                    rx_d    = '0;
                    for (int i = 0; i < CS_COUNT; i++) begin
                        cs_d[i] = (int'(cs_sel_in) != i);
                    end
                    if (!mode_in[0]) begin
                        // CPHA=0: first bit must be on the wire before the first SCLK edge.
                        mosi_d = head_in;
                        tx_d   = tail_in;
                    end else begin
                        mosi_d = 1'b0;
                        tx_d   = data_in;
                    end
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d    = SHIFT;
                    div_d      = '0;
                    half_d     = '0;
                    enter_half = 1'b1;
                    half_odd   = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = HOLD;
                    end else begin
                        half_d     = half_q + BIT_W'(1);
                        enter_half = 1'b1;
                        half_odd   = ~half_q[0];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = IDLE;
                    div_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cs_d    = '1;
                    data_d  = rx_q;
                    sclk_d  = mode_q[1];
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Even halves start with the leading edge. The data-out edge is the leading
        // edge when CPHA=1 and the trailing edge when CPHA=0; the other edge samples.
        if (enter_half) begin
            sclk_d = ~sclk_q;
            if ((~half_odd) == mode_q[0]) begin
                mosi_d = head_q;
                tx_d   = tail_q;
            end else begin
                rx_d = rx_push;
            end
        end
    end

    // State and registered outputs; synchronous reset aborts any transfer on the same edge.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
        end
    end

    assign data_out   = data_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign clk_out    = sclk_q;
    assign serial_out = mosi_q;
    assign cs_out     = cs_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed table, hand sequences and random transfers for spi_master_multi.
// An edge-accurate SPI slave model drives MISO and captures MOSI from observed SCLK edges.
// Expected words, chip selects and timing come from the protocol rules, not from DUT state.
module tb_spi_master_multi;

    localparam int SIZE     = 40;
    localparam int CLK_DIV  = 3;
    localparam int CS_COUNT = 4;
    localparam int CS_WIDTH = 3;
    localparam int BUSY_CYC = (2*SIZE+2)*CLK_DIV;

    logic                clk_in = 1'b0;
    logic                reset_in;
    logic [SIZE-1:0]     data_in;
    logic                send_enable_in;
    logic [1:0]          mode_in;
    logic [CS_WIDTH-1:0] cs_sel_in;
    logic                serial_in;
    logic [SIZE-1:0]     data_out;
    logic                busy_out;
    logic                done_out;
    logic                clk_out;
    logic                serial_out;
    logic [CS_COUNT-1:0] cs_out;

    logic loop_en = 1'b1;
    logic miso    = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    assign serial_in = loop_en ? serial_out : miso;

    spi_master_multi #(
        .SIZE(SIZE), .CLK_DIV(CLK_DIV), .CS_COUNT(CS_COUNT), .CS_WIDTH(CS_WIDTH)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in),
        .send_enable_in(send_enable_in), .mode_in(mode_in), .cs_sel_in(cs_sel_in),
        .serial_in(serial_in), .data_out(data_out), .busy_out(busy_out),
        .done_out(done_out), .clk_out(clk_out), .serial_out(serial_out), .cs_out(cs_out)
    );

    typedef struct {
        logic [SIZE-1:0] data;
        logic [1:0]      mode;
        logic [2:0]      sel;
        logic            loopb;
        logic [SIZE-1:0] slave_word;
        logic [SIZE-1:0] exp_data;
        logic [3:0]      exp_cs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Position of the k-th bit on the wire within a word.
    function automatic int pos(input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return SIZE-1-k;
`endif
    endfunction

    function automatic logic [3:0] model_cs(input logic [2:0] sel);
        if (int'(sel) < CS_COUNT) return ~(4'(1) << sel);
        return 4'hF;
    endfunction

    // Drives one transfer from the current negedge and checks it through its done cycle.
    task automatic run_xfer(input logic [SIZE-1:0] d, input logic [1:0] m, input logic [2:0] sel,
                            input logic lp, input logic [SIZE-1:0] sw, input logic [SIZE-1:0] exp_data,
                            input logic [3:0] exp_cs, input logic hold, input logic gap, input string tag);
        logic [SIZE-1:0] old_do;
        logic [SIZE-1:0] s_rx;
        logic            cpol, cpha, prev_clk, lead, done_seen;
        int              busy_cnt, tog, cs_bad, do_bad, tx_i, rx_i, cyc;
        cpol = m[1]; cpha = m[0];
        busy_cnt = 0; tog = 0; cs_bad = 0; do_bad = 0; tx_i = 0; rx_i = 0; cyc = 0;
        done_seen = 1'b0; prev_clk = 1'b0; s_rx = '0;
        data_in = d; mode_in = m; cs_sel_in = sel; loop_en = lp; send_enable_in = 1'b1;
        if (gap) begin
            @(negedge clk_in);
            chk({tag, "_ignored_in_done_cycle"}, 64'(busy_out), 64'(0));
        end
        old_do = data_out;
        while (1) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                if (!hold) send_enable_in = 1'b0;
                chk({tag, "_accept"}, 64'(busy_out), 64'(1));
                chk({tag, "_setup_clk"}, 64'(clk_out), 64'(cpol));
                prev_clk = clk_out;
                if (!cpha) begin
                    chk({tag, "_first_mosi"}, 64'(serial_out), 64'(d[pos(0)]));
                    miso = sw[pos(0)];
                    tx_i = 1;
                end
            end else if (clk_out !== prev_clk) begin
                tog++;
                lead = (clk_out !== cpol);
                if (lead != cpha) begin
                    if (rx_i < SIZE) begin
                        s_rx[pos(rx_i)] = serial_out;
                        rx_i++;
                    end
                end else if (tx_i < SIZE) begin
                    miso = sw[pos(tx_i)];
                    tx_i++;
                end
                prev_clk = clk_out;
            end
            if (busy_out) begin
                busy_cnt++;
                if (cs_out !== exp_cs) cs_bad++;
                if (data_out !== old_do) do_bad++;
            end
            if (done_out) begin
                done_seen = 1'b1;
                break;
            end
            if (cyc > 2*BUSY_CYC) break;
        end
        chk({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(BUSY_CYC));
        chk({tag, "_sclk_edges"}, 64'(tog), 64'(2*SIZE));
        chk({tag, "_cs_during"}, 64'(cs_bad), 64'(0));
        chk({tag, "_data_out_held"}, 64'(do_bad), 64'(0));
        chk({tag, "_mosi_word"}, 64'(s_rx), 64'(d));
        chk({tag, "_data_out"}, 64'(data_out), 64'(exp_data));
        chk({tag, "_cs_after"}, 64'(cs_out), 64'(4'hF));
        chk({tag, "_busy_after"}, 64'(busy_out), 64'(0));
    endtask

    task automatic idle_check(input logic cpol, input string tag);
        @(negedge clk_in);
        chk({tag, "_done_single"}, 64'(done_out), 64'(0));
        chk({tag, "_clk_idle"}, 64'(clk_out), 64'(cpol));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SIZE-1:0] d, sw, ed;
        logic [1:0]      m;
        logic [2:0]      sel;
        logic            lp;
        int              dn;

        vecs[0] = '{40'h12_3456_789A, 2'd0, 3'd0, 1'b1, 40'h0,            40'h12_3456_789A, 4'b1110};
        vecs[1] = '{40'hA5_0000_00FF, 2'd3, 3'd2, 1'b0, 40'h01_2345_6789, 40'h01_2345_6789, 4'b1011};
        vecs[2] = '{40'h12_3456_789A, 2'd1, 3'd1, 1'b1, 40'h0,            40'h12_3456_789A, 4'b1101};
        vecs[3] = '{40'h12_3456_789A, 2'd2, 3'd3, 1'b1, 40'h0,            40'h12_3456_789A, 4'b0111};
        vecs[4] = '{40'h5A_C3F0_0F1E, 2'd0, 3'd5, 1'b1, 40'h0,            40'h5A_C3F0_0F1E, 4'b1111};
        vecs[5] = '{40'h00_0000_0001, 2'd0, 3'd0, 1'b1, 40'h0,            40'h00_0000_0001, 4'b1110};
        vecs[6] = '{40'h3C_9600_1234, 2'd1, 3'd0, 1'b0, 40'hC3_69FF_EDCB, 40'hC3_69FF_EDCB, 4'b1110};
        vecs[7] = '{40'h81_7E00_FF01, 2'd2, 3'd1, 1'b0, 40'h6B_1D2C_4E8F, 40'h6B_1D2C_4E8F, 4'b1101};

        reset_in = 1'b1; data_in = '0; send_enable_in = 1'b0; mode_in = 2'b00; cs_sel_in = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_done", 64'(done_out), 64'(0));
        chk("rst_clk", 64'(clk_out), 64'(0));
        chk("rst_mosi", 64'(serial_out), 64'(0));
        chk("rst_cs", 64'(cs_out), 64'(4'hF));
        reset_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].data, vecs[i].mode, vecs[i].sel, vecs[i].loopb, vecs[i].slave_word,
                     vecs[i].exp_data, vecs[i].exp_cs, 1'b0, 1'b0, $sformatf("vec%0d", i));
            idle_check(vecs[i].mode[1], $sformatf("vec%0d", i));
        end

        // send_enable_in held high: exactly one transfer, the next accepted one cycle after done.
        run_xfer(40'hF0_0F_AA_55_C3, 2'd0, 3'd1, 1'b1, 40'h0, 40'hF0_0F_AA_55_C3, 4'b1101, 1'b1, 1'b0, "b2b_a");
        run_xfer(40'h0F_F0_55_AA_3C, 2'd3, 3'd3, 1'b1, 40'h0, 40'h0F_F0_55_AA_3C, 4'b0111, 1'b0, 1'b1, "b2b_b");
        idle_check(1'b1, "b2b_b");

        // Reset part way through a CPOL=1 transfer.
        data_in = 40'hDE_AD_BE_EF_01; mode_in = 2'd3; cs_sel_in = 3'd1; loop_en = 1'b1; send_enable_in = 1'b1;
        @(negedge clk_in);
        send_enable_in = 1'b0;
        chk("rst_mid_started", 64'(busy_out), 64'(1));
        repeat (99) @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        chk("rst_mid_cs", 64'(cs_out), 64'(4'hF));
        chk("rst_mid_busy", 64'(busy_out), 64'(0));
        chk("rst_mid_clk", 64'(clk_out), 64'(0));
        chk("rst_mid_done", 64'(done_out), 64'(0));
        dn = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (done_out) dn++;
        end
        chk("rst_mid_no_done", 64'(dn), 64'(0));
        run_xfer(40'h13_57_9B_DF_02, 2'd1, 3'd2, 1'b0, 40'hAB_CD_EF_01_23, 40'hAB_CD_EF_01_23, 4'b1011, 1'b0, 1'b0, "post_rst");
        idle_check(1'b0, "post_rst");

        // Random transfers against the protocol-level model.
        for (int r = 0; r < 8; r++) begin
            d   = 40'({$urandom, $urandom});
            sw  = 40'({$urandom, $urandom});
            m   = 2'($urandom_range(0, 3));
            sel = 3'($urandom_range(0, 7));
            lp  = 1'($urandom_range(0, 1));
            ed  = lp ? d : sw;
            run_xfer(d, m, sel, lp, sw, ed, model_cs(sel), 1'b0, 1'b0, $sformatf("rand%0d", r));
            idle_check(m[1], $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised full-duplex SPI master; successor to the fixed single-device `spi` block.
- Adds several things the old block lacks: a runtime-selectable SPI mode (CPOL/CPHA), multiple active-low chip selects, a start/busy/done handshake and a clean synchronous reset.
- Sits between the stepper control logic and several SPI driver chips that share one bus, exchanging one SIZE-bit datagram per transfer.

Parameters:
- SIZE, 40: datagram width in bits; SIZE ≥ 2.
- CLK_DIV, 3: system cycles per SCLK half-period; CLK_DIV ≥ 1.
- CS_COUNT, 4: number of chip-select lines; CS_COUNT ≥ 1.
- CS_WIDTH, 2: width of cs_sel_in; must satisfy 2^CS_WIDTH ≥ CS_COUNT.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- data_in  input  SIZE  word to transmit; latched on accepted start.
- send_enable_in  input  1  start request; sampled each cycle.
- mode_in  input  2  {CPOL,CPHA}; latched on accepted start.
- cs_sel_in  input  CS_WIDTH  target device index; latched on accepted start.
- serial_in  input  1  MISO.
- data_out  output  SIZE  last received word.
- busy_out  output  1  high while a transfer is in progress.
- done_out  output  1  one-cycle pulse at transfer end.
- clk_out  output  1  SCLK.
- serial_out  output  1  MOSI.
- cs_out  output  CS_COUNT  active-low chip selects.

Behaviour:
- Reset values: data_out=0, busy_out=0, done_out=0, clk_out=0, serial_out=0, cs_out=all ones. All internal state returns to IDLE. Reset mid-transfer aborts the transfer on the same edge; no done_out pulse is issued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - clk_out follows the latched CPOL of the previous transfer (0 after reset).
  - A start is accepted when send_enable_in=1 in IDLE.
  - On the next edge: data_in, mode_in and cs_sel_in are latched; busy_out=1; cs_out[cs_sel] driven low; state moves to SETUP.
- SETUP:
  - clk_out=CPOL for CLK_DIV cycles.
  - If CPHA=0, serial_out carries the first data bit (MSB) from the SETUP entry cycle.
- SHIFT:
  - 2*SIZE SCLK half-periods of CLK_DIV cycles each; clk_out toggles at every half-period boundary.
  - CPHA=0: serial_in is sampled on the leading edge; serial_out advances on the trailing edge.
  - CPHA=1: serial_out advances on the leading edge, including the first bit; serial_in is sampled on the trailing edge.
  - Received bits shift into an internal register, MSB first.
- HOLD:
  - clk_out=CPOL for CLK_DIV cycles.
  - On exit, on the same edge: cs_out returns to all ones, busy_out=0, done_out=1 for one cycle, data_out is loaded with the received word, and state returns to IDLE.
- Latency: busy_out is high for exactly (2*SIZE+2)*CLK_DIV cycles.
- Handshake: send_enable_in is ignored while busy_out=1, including in the done_out cycle. A start asserted on the cycle after done_out is accepted, giving back-to-back transfers with one idle cycle between them.
- Out-of-range cs_sel (≥ CS_COUNT): the transfer runs normally with full timing, but cs_out stays all ones.
- data_out holds its value between transfers and changes only in the done_out cycle.
- The bit counter is sized ceil(log2(2*SIZE+1)); the divider counter is sized ceil(log2(CLK_DIV+1)). Neither counter wraps within a transfer.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: both transmit and receive are LSB first. data_in[0] goes out first, and the first received bit lands in data_out[0].
- Undefined: MSB first on both directions, as described above.
- Timing, handshake and reset behaviour are identical in both cases.

Test Plan:
- SIZE=40, CLK_DIV=3, CS_COUNT=4; mode 0, cs_sel=0, data_in=40'h12_3456_789A, serial_out looped back to serial_in -> busy_out high for 246 cycles; cs_out=4'b1110 throughout; 80 clk_out edges, idle low; done_out single pulse; data_out=40'h12_3456_789A.
- Mode 3, cs_sel=2, data_in=40'hA5_0000_00FF, slave model returning 40'h01_2345_6789 -> clk_out idles high; cs_out=4'b1011 during the transfer; MOSI bitstream matches A5..FF MSB first; data_out=40'h01_2345_6789.
- Modes 1 and 2 each with the same loopback word -> data_out equals data_in; sample/shift edges checked against CPHA by an edge-accurate slave model.
- send_enable_in held high throughout a transfer -> exactly one transfer until done_out; a second transfer starts one cycle after done_out; cs_sel=5 with CS_WIDTH=3 -> cs_out stays 4'b1111 and done still occurs at 246 cycles.
- reset_in pulsed at cycle 100 of a transfer -> next edge: cs_out=4'b1111, busy_out=0, clk_out=0, no done_out pulse; a new start afterwards completes normally.
- With SPI_LSB_FIRST_EN defined, data_in=40'h00_0000_0001 looped back -> first MOSI bit is 1; data_out=40'h00_0000_0001.
